// File: rtl/coin_pkg.sv
// Shared types and constants for the coin dispense sequencer.
package coin_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BACK_ACK,
        BACK_WAIT,
        FRONT_ACK,
        FRONT_WAIT,
        FAULT
    } state_t;

    localparam int DEFAULT_MAX_COINS      = 20;
    localparam int DEFAULT_TIMEOUT_CYCLES = 50_000_000;

    localparam logic SERVO_BACK  = 1'b1;
    localparam logic SERVO_FRONT = 1'b0;

endpackage

// File: rtl/coin_dispense_sequencer_stall_timer.sv
// Wait-state watchdog: counts enabled cycles and flags the terminal count.
module stall_timer
    import coin_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic clr,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [TIMER_W-1:0] count;

    // Saturates at the terminal count so it can never wrap back to zero.
    always_ff @(posedge clk) begin
        if (!clr) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + TIMER_W'(1);
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/coin_dispense_sequencer.sv
// Sequences one back/front servo stroke per requested coin with a stall watchdog.
module coin_dispense_sequencer
    import coin_pkg::*;
#(
    parameter int MAX_COINS      = DEFAULT_MAX_COINS,
    parameter int COUNT_W        = 5,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               req_valid,
    input  logic [COUNT_W-1:0] req_count,
    output logic               req_ready,
    output logic [31:0]        servo_ctrl,
    input  logic               servo_back_done,
    input  logic               servo_front_done,
    output logic               busy,
    output logic [COUNT_W-1:0] coins_left,
    output logic               done_pulse,
    output logic               fault
);

    localparam logic [COUNT_W-1:0] MAX_COUNT = COUNT_W'(MAX_COINS);

    state_t             state;
    state_t             state_next;
    logic               push;
    logic               push_next;
    logic [COUNT_W-1:0] coins_next;
    logic [COUNT_W-1:0] clamped;
    logic               done_next;
    logic               fault_next;
    logic               wait_state;
    logic               timer_clear;
    logic               timer_expired;

    assign clamped     = (req_count > MAX_COUNT) ? MAX_COUNT : req_count;
    assign wait_state  = (state == BACK_ACK) || (state == BACK_WAIT) ||
                         (state == FRONT_ACK) || (state == FRONT_WAIT);
    assign timer_clear = (state_next != state);

    stall_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_stall_timer (
        .clk     (clk),
        .clr     (clr),
        .clear   (timer_clear),
        .enable  (wait_state),
        .expired (timer_expired)
    );

    always_comb begin
        state_next = state;
        push_next  = push;
        coins_next = coins_left;
        done_next  = 1'b0;
        fault_next = fault;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (clamped == '0) begin
                        done_next = 1'b1;
                    end else begin
                        coins_next = clamped;
                        push_next  = SERVO_BACK;
                        state_next = BACK_ACK;
                    end
                end
            end
            BACK_ACK: begin
                if (!servo_back_done) state_next = BACK_WAIT;
            end
            BACK_WAIT: begin
                if (servo_back_done) begin
                    push_next  = SERVO_FRONT;
                    state_next = FRONT_ACK;
                end
            end
            FRONT_ACK: begin
                if (!servo_front_done) state_next = FRONT_WAIT;
            end
            FRONT_WAIT: begin
                if (servo_front_done) begin
                    if (coins_left <= COUNT_W'(1)) begin
                        coins_next = '0;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        coins_next = coins_left - COUNT_W'(1);
                        push_next  = SERVO_BACK;
                        state_next = BACK_ACK;
                    end
                end
            end
            FAULT: begin
            end
            default: state_next = IDLE;
        endcase
        // A completed handshake on the expiring cycle still counts as progress.
        if (wait_state && (state_next == state) && timer_expired) begin
            state_next = FAULT;
            push_next  = SERVO_FRONT;
            fault_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state      <= IDLE;
            push       <= SERVO_FRONT;
            coins_left <= '0;
            done_pulse <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state      <= state_next;
            push       <= push_next;
            coins_left <= coins_next;
            done_pulse <= done_next;
            fault      <= fault_next;
        end
    end

    assign servo_ctrl = {31'b0, push};
    assign req_ready  = (state == IDLE);
    assign busy       = (state != IDLE) && (state != FAULT);

endmodule
